// File: rtl/pipeline_pkg.sv
// Shared constants for the RV32 pipeline: ALU opcodes, result-select codes,
// and the operand-forwarding select enum used by the execute stage.
package pipeline_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_EXM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of everything the execute stage exchanges with its neighbours:
// ID/EX fields in, writeback bypass in, EX/MEM register and hazard/forward
// indications out. The slave side is the execute stage itself.
interface ex_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            stall;
  logic            flush;
  logic            valid_in;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] rd1_in;
  logic [XLEN-1:0] rd2_in;
  logic [XLEN-1:0] immext_in;
  logic [REGW-1:0] rs1_in;
  logic [REGW-1:0] rs2_in;
  logic [REGW-1:0] rd_in;
  logic [2:0]      alucontrol_in;
  logic            alusrc_in;
  logic            regwrite_in;
  logic            memwrite_in;
  logic [1:0]      resultsrc_in;
  logic            wb_regwrite;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_result;
  logic            valid_out;
  logic            regwrite_out;
  logic            memwrite_out;
  logic            zero_out;
  logic [XLEN-1:0] aluresult_out;
  logic [XLEN-1:0] writedata_out;
  logic [XLEN-1:0] pcplus4_out;
  logic [REGW-1:0] rd_out;
  logic [1:0]      resultsrc_out;
  logic            load_use;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  modport slave (
    input  stall, flush, valid_in, pc_in, rd1_in, rd2_in, immext_in,
           rs1_in, rs2_in, rd_in, alucontrol_in, alusrc_in, regwrite_in,
           memwrite_in, resultsrc_in, wb_regwrite, wb_rd, wb_result,
    output valid_out, regwrite_out, memwrite_out, zero_out, aluresult_out,
           writedata_out, pcplus4_out, rd_out, resultsrc_out, load_use,
           fwd_a, fwd_b
  );

  modport master (
    output stall, flush, valid_in, pc_in, rd1_in, rd2_in, immext_in,
           rs1_in, rs2_in, rd_in, alucontrol_in, alusrc_in, regwrite_in,
           memwrite_in, resultsrc_in, wb_regwrite, wb_rd, wb_result,
    input  valid_out, regwrite_out, memwrite_out, zero_out, aluresult_out,
           writedata_out, pcplus4_out, rd_out, resultsrc_out, load_use,
           fwd_a, fwd_b
  );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32 ALU: add/sub/and/or/xor/signed slt, unknown codes give 0.
module alu
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  // Operation select; results wrap naturally at XLEN bits.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding from EX/MEM and WB, ALU, load-use bubble
// insertion, and the EX/MEM pipeline register.
module ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input logic        clk,
  input logic        reset,
  ex_stage_if.slave  bus
);

  logic            r_valid;
  logic            r_regwrite;
  logic            r_memwrite;
  logic            r_zero;
  logic [XLEN-1:0] r_aluresult;
  logic [XLEN-1:0] r_writedata;
  logic [XLEN-1:0] r_pcplus4;
  logic [REGW-1:0] r_rd;
  logic [1:0]      r_resultsrc;

  logic            w_exm_ok;
  logic [XLEN-1:0] w_exm_val;
  fwd_sel_e        w_fwd_a;
  fwd_sel_e        w_fwd_b;
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_y;
  logic            w_alu_zero;
  logic            w_load_use;

  // A load in EX/MEM has no data yet, so it never forwards; it stalls instead.
  function automatic fwd_sel_e sel_fwd(
    input logic [REGW-1:0] rs,
    input logic            exm_ok,
    input logic [REGW-1:0] exm_rd,
    input logic            wb_ok,
    input logic [REGW-1:0] wb_rd
  );
    if (rs == '0)                       return FWD_RF;
    else if (exm_ok && (exm_rd == rs))  return FWD_EXM;
    else if (wb_ok && (wb_rd == rs))    return FWD_WB;
    else                                return FWD_RF;
  endfunction

  assign w_exm_ok  = r_valid & r_regwrite & (r_resultsrc != RESULT_LOAD);
  assign w_exm_val = (r_resultsrc == RESULT_PC4) ? r_pcplus4 : r_aluresult;
  assign w_fwd_a   = sel_fwd(bus.rs1_in, w_exm_ok, r_rd, bus.wb_regwrite, bus.wb_rd);
  assign w_fwd_b   = sel_fwd(bus.rs2_in, w_exm_ok, r_rd, bus.wb_regwrite, bus.wb_rd);

  // Forwarding muxes for both source operands.
  always_comb begin
    w_src_a   = bus.rd1_in;
    w_rs2_val = bus.rd2_in;
    case (w_fwd_a)
      FWD_EXM: w_src_a = w_exm_val;
      FWD_WB:  w_src_a = bus.wb_result;
      default: w_src_a = bus.rd1_in;
    endcase
    case (w_fwd_b)
      FWD_EXM: w_rs2_val = w_exm_val;
      FWD_WB:  w_rs2_val = bus.wb_result;
      default: w_rs2_val = bus.rd2_in;
    endcase
  end

  assign w_src_b = bus.alusrc_in ? bus.immext_in : w_rs2_val;

  // rs2 match counts even for immediate ops: the hazard check is index-only.
  assign w_load_use = bus.valid_in & r_valid & r_regwrite &
                      (r_resultsrc == RESULT_LOAD) & (r_rd != '0) &
                      ((r_rd == bus.rs1_in) | (r_rd == bus.rs2_in));

  alu #(.XLEN(XLEN)) u_alu (
    .a    (w_src_a),
    .b    (w_src_b),
    .op   (bus.alucontrol_in),
    .y    (w_alu_y),
    .zero (w_alu_zero)
  );

  // EX/MEM register: reset > flush > stall(hold) > load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (!reset || bus.flush || (!bus.stall && w_load_use)) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_zero      <= 1'b0;
      r_aluresult <= '0;
      r_writedata <= '0;
      r_pcplus4   <= '0;
      r_rd        <= '0;
      r_resultsrc <= '0;
    end else if (!bus.stall) begin
      r_valid     <= bus.valid_in;
      r_regwrite  <= bus.regwrite_in & bus.valid_in;
      r_memwrite  <= bus.memwrite_in & bus.valid_in;
      r_zero      <= w_alu_zero;
      r_aluresult <= w_alu_y;
      r_writedata <= w_rs2_val;
      r_pcplus4   <= bus.pc_in + XLEN'(4);
      r_rd        <= bus.rd_in;
      r_resultsrc <= bus.resultsrc_in;
    end
  end

  assign bus.valid_out     = r_valid;
  assign bus.regwrite_out  = r_regwrite;
  assign bus.memwrite_out  = r_memwrite;
  assign bus.zero_out      = r_zero;
  assign bus.aluresult_out = r_aluresult;
  assign bus.writedata_out = r_writedata;
  assign bus.pcplus4_out   = r_pcplus4;
  assign bus.rd_out        = r_rd;
  assign bus.resultsrc_out = r_resultsrc;
  assign bus.load_use      = w_load_use;
  assign bus.fwd_a         = w_fwd_a;
  assign bus.fwd_b         = w_fwd_b;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32 pipeline, the consumer side of the ID/EX register. Each cycle it takes the decoded fields from ID/EX and resolves operand forwarding from its own EX/MEM register and from writeback. It then runs the ALU and registers the result plus downstream control into the EX/MEM outputs. It also flags load-use hazards and inserts the required bubble; holding ID/EX is the hazard controller's job.

## Interface
Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- stall  in  1  downstream stall; hold EX/MEM outputs
- flush  in  1  kill current capture; load bubble
- valid_in  in  1  ID/EX slot holds a real instruction
- pc_in, rd1_in, rd2_in, immext_in  in  XLEN  ID/EX data fields
- rs1_in, rs2_in, rd_in  in  REGW  ID/EX register indices
- alucontrol_in  in  3  ALU op
- alusrc_in, regwrite_in, memwrite_in  in  1  ID/EX control
- resultsrc_in  in  2  result select: 00 ALU, 01 load, 10 PC+4
- wb_regwrite  in  1  WB stage writes register file
- wb_rd  in  REGW  WB destination
- wb_result  in  XLEN  WB write value
- valid_out, regwrite_out, memwrite_out, zero_out  out  1  EX/MEM registered flags
- aluresult_out, writedata_out, pcplus4_out  out  XLEN  EX/MEM registered data
- rd_out  out  REGW  EX/MEM destination
- resultsrc_out  out  2  EX/MEM result select
- load_use  out  1  combinational; EX/MEM load feeds a current source
- fwd_a, fwd_b  out  2  combinational forward select: 00 regfile, 01 WB, 10 EX/MEM

## Operation
- ALU codes: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed), 100 xor; others give 0. Results are taken mod 2^XLEN.
- srcA = forwarded rs1 value. srcB = immext_in if alusrc_in, else the forwarded rs2 value.
- writedata = forwarded rs2 value, whatever alusrc_in is.
- pcplus4 = pc_in + 4, wrapping.
- zero = (aluresult == 0).
- EX/MEM hit on source rsX: valid_out & regwrite_out & rd_out≠0 & rd_out==rsX & resultsrc_out≠01. Forwards aluresult_out, or pcplus4_out when resultsrc_out==10.
- WB hit: wb_regwrite & wb_rd≠0 & wb_rd==rsX. Forwards wb_result.
- Priority: EX/MEM > WB > regfile. Source index 0 always selects regfile.
- load_use = valid_in & valid_out & regwrite_out & resultsrc_out==01 & rd_out≠0 & (rd_out==rs1_in | rd_out==rs2_in). A match on rs2 counts even when alusrc_in=1.
- Register update priority, highest first:
  - reset low: all outputs 0.
  - flush: bubble.
  - stall: hold all EX/MEM outputs.
  - load_use: bubble.
  - otherwise: capture, with valid_out=valid_in and regwrite/memwrite ANDed with valid_in.
- Bubble: valid_out, regwrite_out and memwrite_out = 0. Data fields are don't-care and are driven 0.

## Timing
- Latency 1 cycle from ID/EX inputs to EX/MEM outputs.
- Back-to-back dependent ALU ops take no stall.
- A load followed by a dependent op costs one bubble. The next cycle the operand is taken from WB.
- Reset value of every registered output is 0, applied on the first clk edge with reset low. Reset mid-stall still clears.
- Simultaneous flush and stall: flush wins.
- load_use asserted together with stall: hold. load_use then stays asserted until the stall releases.
- Forward paths and load_use are combinational on same-cycle inputs and registered outputs.

## Structure
- pipeline_pkg holds:
  - ALU opcode localparams.
  - RESULT_ALU/LOAD/PC4 constants.
  - FWD_RF/WB/EXM select enum.
- Single sub-module alu (combinational, XLEN-parameterised): inputs a, b, op; outputs y, zero.
- Forwarding muxes and the EX/MEM register live in ex_stage.

## Test plan
- Reset low 2 cycles with inputs nonzero -> all outputs 0. Release and apply add: rd1=5, rd2=7, rd=3 -> aluresult_out=12, regwrite_out=1, valid_out=1.
- Two back-to-back ops:
  - x3=0xAAAAAAAA+1 (rd1=0xAAAAAAAA, rd2=1).
  - Then sub with rs1=3, rd1_in=0, rd2=0xA.
  - Expected: fwd_a=10, result 0xAAAAAAA1.
- WB forward: wb_regwrite=1, wb_rd=2, wb_result=0x55555555, rs2_in=2, alusrc=0, and op -> writedata_out=0x55555555. Same with wb_rd=0 -> regfile value used.
- Load-use:
  - EX/MEM holds a load to x4.
  - Next op reads rs1=4 -> load_use=1, bubble captured (valid_out=0, regwrite_out=0).
  - Following cycle, with wb_rd=4, wb_result=0x10 -> fwd_a=01.
- Stall, then flush+stall:
  - stall=1 for 3 cycles -> outputs unchanged.
  - flush=1 with stall=1 -> valid_out=0 next edge.
- Edges:
  - slt -1 vs 1 -> 1.
  - pc_in=0xFFFFFFFC -> pcplus4_out=0.
  - sub equal operands -> zero_out=1.
